// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: walks each instruction through fetch/decode/mem/exec/branch/writeback.
// Optional illegal-opcode trap (HALT state, sticky illegal) is built when ILLEGAL_OP_TRAP_EN is defined.
module multicycle_control #(
  parameter int NUM_WORDS = 4,
  parameter int WSEL_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic                 mem_ready,
  input  logic                 alu_done,
  input  logic                 flag_eq,
  input  logic                 flag_gt,
  input  logic                 flag_lt,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 inst_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WSEL_W-1:0]    word_sel,
  output logic [NUM_WORDS-1:0] data_out,
  output logic                 reg_write,
  output logic                 alu_start,
  output logic [5:0]           alu_op,
  output logic [2:0]           state_o,
  output logic                 illegal
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEM    = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    BRANCH = 3'd5
`ifdef ILLEGAL_OP_TRAP_EN
    , HALT = 3'd6
`endif
  } stateT;

  stateT             state, nextState;
  logic [5:0]        opQ, nextOpQ;
  logic [WSEL_W-1:0] k, nextK;
  logic              startDone, nextStartDone;
  logic              illegalQ, nextIllegal;

  logic isMld, isMstr, isInt, isCmp, take;

  always_comb begin
    isMld  = (opQ == 6'b000000);
    isMstr = (opQ == 6'b000001);
    isInt  = (opQ[5:3] == 3'b010);
    isCmp  = (opQ == 6'b011000) || (opQ == 6'b011001);
    take   = (opQ == 6'b011100) ||
             ((opQ == 6'b011101) && flag_eq) ||
             ((opQ == 6'b011110) && flag_gt) ||
             ((opQ == 6'b011111) && flag_lt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      opQ       <= '0;
      k         <= '0;
      startDone <= 1'b0;
      illegalQ  <= 1'b0;
    end else begin
      state     <= nextState;
      opQ       <= nextOpQ;
      k         <= nextK;
      startDone <= nextStartDone;
      illegalQ  <= nextIllegal;
    end
  end

  always_comb begin
    nextState     = state;
    nextOpQ       = opQ;
    nextK         = k;
    nextStartDone = startDone;
    nextIllegal   = illegalQ;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    inst_write    = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    word_sel      = '0;
    data_out      = '0;
    reg_write     = 1'b0;
    alu_start     = 1'b0;

    case (state)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          inst_write = 1'b1;
          pc_write   = 1'b1;
          nextState  = DECODE;
        end
      end
      DECODE: begin
        nextOpQ = op;
        nextK   = '0;
        if (op == 6'b000000 || op == 6'b000001)
          nextState = MEM;
        else if (op inside {6'b001000, 6'b001001, 6'b001100, 6'b001101} ||
                 op[5:3] == 3'b010 || op == 6'b011000 || op == 6'b011001)
          nextState = EXEC;
        else if (op[5:2] == 4'b0111)
          nextState = BRANCH;
        else if (op == 6'b100100)
          nextState = WB;
        else begin
`ifdef ILLEGAL_OP_TRAP_EN
          nextState   = HALT;
          nextIllegal = 1'b1;
`else
          nextState = FETCH;
`endif
        end
      end
      MEM: begin
        word_sel  = k;
        mem_read  = isMld;
        mem_write = isMstr;
        if (mem_ready) begin
          if (isMld) data_out = NUM_WORDS'(1) << k;
          if (k == WSEL_W'(NUM_WORDS - 1)) begin
            nextK     = '0;
            nextState = isMld ? WB : FETCH;
          end else begin
            nextK = k + 1'b1;
          end
        end
      end
      EXEC: begin
        // alu_done is only honoured once the launch pulse has gone out
        if (!startDone) begin
          alu_start     = 1'b1;
          nextStartDone = 1'b1;
        end else if (alu_done) begin
          nextStartDone = 1'b0;
          nextState     = isCmp ? FETCH : WB;
        end
      end
      WB: begin
        reg_write = 1'b1;
        data_out  = isInt ? NUM_WORDS'(1) : '1;
        nextState = FETCH;
      end
      BRANCH: begin
        pc_src    = 1'b1;
        pc_write  = take;
        nextState = FETCH;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      HALT: nextState = HALT;
`endif
      default: nextState = FETCH;
    endcase

    // Strobes are forced low for the whole time reset is held, not just after the edge
    if (reset) begin
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      inst_write = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      word_sel   = '0;
      data_out   = '0;
      reg_write  = 1'b0;
      alu_start  = 1'b0;
    end
  end

  assign alu_op  = opQ;
  assign state_o = state;
`ifdef ILLEGAL_OP_TRAP_EN
  assign illegal = illegalQ;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the matrix/integer processor.
- Replaces single-cycle opcode decoding with an FSM that walks each instruction through fetch, decode, memory, execute, branch and writeback.
- Handles per-word memory handshakes for 4-word matrix load/store, waits on multi-cycle ALU ops (MMUL, IDIV), and resolves conditional jumps from ALU flags.
- Sits between the instruction register/memory port and the ALU/register file.

Parameters:
- NUM_WORDS, 4: words per matrix transfer; also the width of data_out.
- WSEL_W, 2: width of word_sel; must equal clog2(NUM_WORDS).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- op  in  6  opcode field from the instruction bus; sampled in DECODE.
- mem_ready  in  1  memory accepts or returns the current word this cycle.
- alu_done  in  1  ALU result valid.
- flag_eq  in  1  ALU compare flag.
- flag_gt  in  1  ALU compare flag.
- flag_lt  in  1  ALU compare flag.
- pc_write  out  1  PC update strobe.
- pc_src  out  1  0 = PC+1, 1 = jump target.
- inst_write  out  1  instruction register load strobe.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- word_sel  out  WSEL_W  matrix word index for the memory address.
- data_out  out  NUM_WORDS  lane enables: in MEM, one-hot load-buffer capture; in WB, register-file lane write enables.
- reg_write  out  1  register file write strobe.
- alu_start  out  1  one-cycle ALU launch pulse.
- alu_op  out  6  latched opcode op_q.
- state_o  out  3  current state, for debug.
- illegal  out  1  illegal opcode trap (used only with the optional feature).

Behaviour:
- Reset, asynchronous: state=FETCH, op_q=0, word counter k=0, start_done=0, illegal=0, all strobes 0.
- Reset asserted mid-operation aborts immediately; first state after release is FETCH.
- Output timing: outputs decode from state, op_q and k. inst_write, pc_write (in FETCH) and data_out (in MEM) are additionally gated by mem_ready in the same cycle.
- State encoding: FETCH=0, DECODE=1, MEM=2, EXEC=3, WB=4, BRANCH=5, HALT=6.

FETCH:
- mem_read=1.
- If mem_ready: inst_write=1, pc_write=1, pc_src=0, go to DECODE. Otherwise stay in FETCH.

DECODE: latch op into op_q and dispatch.
- 000000 MLD, 000001 MSTR: go to MEM, k=0.
- 001000 MADD, 001001 MSUB, 001100 MMUL, 001101 SMUL: go to EXEC (matrix class).
- 010000 to 010111 (IADD, ISUB, IMUL, IDIV, IADDI, ISUBI, IMULI, IDIVI): go to EXEC (integer class).
- 011000 MCMP, 011001 ICMP: go to EXEC (compare class).
- 011100 JMP, 011101 JEQ, 011110 JGT, 011111 JLS: go to BRANCH.
- 100100 ZERO: go to WB (matrix class).
- Any other opcode: illegal (see Optional Feature).

MEM:
- word_sel=k.
- MLD: mem_read=1. On mem_ready, data_out=one-hot(k).
- MSTR: mem_write=1.
- On mem_ready: k increments; when k=NUM_WORDS-1, MLD goes to WB and MSTR goes to FETCH.
- mem_ready low stalls indefinitely with all outputs held.
- k wraps to 0 on exit.

EXEC:
- alu_start=1 only in the first EXEC cycle (start_done flag).
- alu_done is honoured from the cycle after alu_start; alu_done during the start cycle is ignored.
- On alu_done: compare class goes to FETCH (flags only, no write); matrix and integer classes go to WB.

WB:
- reg_write=1 for exactly one cycle, then go to FETCH.
- data_out=all-ones for matrix class and MLD; data_out=0001 for integer class.

BRANCH (one cycle):
- take = JMP | (JEQ & flag_eq) | (JGT & flag_gt) | (JLS & flag_lt). Flags are sampled in this cycle.
- pc_write=take, pc_src=1, then go to FETCH.

Invariants:
- mem_read and mem_write are never asserted together.
- reg_write is never asserted outside WB.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: an illegal opcode goes DECODE to HALT. illegal=1 is held and all strobes are 0 until reset.
- Undefined: an illegal opcode is a NOP (DECODE to FETCH, no writes). illegal is tied to 0 and the HALT state is not built.

Test Plan:
- MLD, mem_ready=1 throughout -> 7 cycles FETCH, DECODE, MEM x4, WB; data_out 0001, 0010, 0100, 1000, then 1111 with reg_write=1.
- MSTR, mem_ready low for 3 cycles at k=2 -> word_sel=2 and mem_write=1 held; no advance; exits to FETCH after word 3 is accepted.
- IDIV, alu_done asserted 5 cycles after start -> exactly one alu_start pulse; WB data_out=0001, reg_write=1; alu_op=010011.
- JEQ with flag_eq=0 -> pc_write=0 in BRANCH; repeat with flag_eq=1 -> pc_write=1, pc_src=1; JMP ignores flags.
- Opcode 111111 -> with ILLEGAL_OP_TRAP_EN: state_o=6, illegal=1 sticky; without: returns to FETCH, no writes.
- reset asserted during MEM k=1 -> all outputs 0 immediately; after release FETCH, k=0, mem_read=1.
